dmem_arbiter: RTL and testbench

Shares the processor's single data-memory port between the single-cycle CPU datapath and an external requester (program loader / debug DMA). Grants ownership with a two-state FSM, bounds external bursts, and prevents external starvation. Stalls the CPU while the external side owns the port; the stall freezes PC update and register write-back.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_perf.sv | 26 ++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_EXT = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  // Counter width for a count range of n states; a 0-bit counter is not
  // legal, so ranges of 1 or 2 both use a single bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// Saturating performance counters for the data-memory arbiter: cycles the
// CPU spent stalled and external beats granted. Built only when the top is
// compiled with DMEM_ARB_PERF_EN.
module dmem_arb_perf (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        stall,
  input  logic        beat,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_ext_beats
);

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      perf_stall_cycles <= '0;
      perf_ext_beats    <= '0;
    end else begin
      if (stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (beat && (perf_ext_beats != '1))
        perf_ext_beats <= perf_ext_beats + 32'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the single-cycle CPU datapath and an
// external requester (loader / debug DMA). External bursts are capped at
// MAX_BURST beats; a pending external request waits at most STARVE_LIMIT
// cycles behind a busy CPU. Define DMEM_ARB_PERF_EN to add the
// perf_stall_cycles / perf_ext_beats counter outputs.
//
// state | meaning
// S_CPU | CPU owns the port; external request waits or is admitted
// S_EXT | external side owns the port while it keeps requesting
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_ext_beats,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = cnt_w(STARVE_LIMIT);
  localparam int BW = cnt_w(MAX_BURST);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

  arb_state_e    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          cpu_req;
  logic          ext_own;

  assign cpu_req = cpu_read | cpu_write;

  // Ownership decision, next state and counter updates.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    burst_nxt  = burst_cnt;
    ext_own    = 1'b0;
    case (state)
      S_CPU: begin
        if (ext_req) begin
          if (!cpu_req || (starve_cnt == STARVE_LAST)) begin
            state_nxt  = S_EXT;
            starve_nxt = '0;
            burst_nxt  = '0;
          end else begin
            // Cannot pass STARVE_LAST: reaching it forces the handover.
            starve_nxt = starve_cnt + 1'b1;
          end
        end else begin
          starve_nxt = '0;
        end
      end
      S_EXT: begin
        if (ext_req) begin
          ext_own = 1'b1;
          if (burst_cnt == BURST_LAST) state_nxt = S_CPU;
          else                         burst_nxt = burst_cnt + 1'b1;
        end else begin
          // Requester went quiet: hand the port straight back this cycle.
          state_nxt = S_CPU;
        end
      end
      default: state_nxt = S_CPU;
    endcase
  end

  // Port mux; a CPU write wins over a simultaneous read so the memory never
  // sees both strobes.
  always_comb begin
    mem_addr  = ext_own ? ext_addr  : cpu_addr;
    mem_wdata = ext_own ? ext_wdata : cpu_wdata;
    mem_read  = ext_own ? ~ext_we   : (cpu_read & ~cpu_write);
    mem_write = ext_own ? ext_we    : cpu_write;
    ext_gnt   = ext_own;
    cpu_stall = ext_own & cpu_req;
    cpu_rdata = mem_rdata;
  end

  // State, counters and the registered external read return.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      state      <= S_CPU;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
      ext_rvalid <= ext_own & ~ext_we;
      if (ext_own && !ext_we) ext_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .CLK               (CLK),
    .resetl            (resetl),
    .stall             (cpu_stall),
    .beat              (ext_gnt),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_ext_beats    (perf_ext_beats)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// burst / starvation / read-return / reset sequences, then random traffic
// against a cycle-level reference model of the ownership rules.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int SL = 8;

  logic          CLK = 1'b0;
  logic          resetl;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_ext_beats;
`endif

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .STARVE_LIMIT(SL)) dut (
    .CLK(CLK), .resetl(resetl),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_ext_beats(perf_ext_beats),
`endif
    .mem_rdata(mem_rdata)
  );

  // Data memory driven by the DUT's port (word index = addr[10:3]).
  logic [DW-1:0] mem [0:255];
  logic          mem_clear;
  assign mem_rdata = mem[mem_addr[10:3]];

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (mem_write) begin
      mem[mem_addr[10:3]] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the port, how long the external side has
  // been kept waiting, how many beats it has had since admission.
  logic [DW-1:0] exp_mem [0:255];
  bit            m_ext;
  int            m_wait, m_beats;
  bit            m_rv;
  logic [DW-1:0] m_rdata;
  int            stall_run, wait_run;
  logic          last_gnt;

  task automatic drive(input logic rd, input logic wr, input logic [63:0] ca,
                       input logic [63:0] cw, input logic er, input logic ew,
                       input logic [63:0] ea, input logic [63:0] ewd);
    cpu_read = rd; cpu_write = wr; cpu_addr = ca; cpu_wdata = cw;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ewd;
  endtask

  task automatic sample();
    bit own;
    @(negedge CLK);
    own = m_ext && ext_req;
    chk("ext_gnt",   ext_gnt,   own);
    chk("cpu_stall", cpu_stall, own && (cpu_read || cpu_write));
    chk("mem_addr",  mem_addr,  own ? ext_addr : cpu_addr);
    chk("mem_read",  mem_read,  own ? !ext_we : cpu_read);
    chk("mem_write", mem_write, own ? ext_we : cpu_write);
    if (own ? ext_we : cpu_write)
      chk("mem_wdata", mem_wdata, own ? ext_wdata : cpu_wdata);
    if (!own && cpu_read)
      chk("cpu_rdata", cpu_rdata, exp_mem[cpu_addr[10:3]]);
    chk("ext_rvalid", ext_rvalid, m_rv);
    if (m_rv) chk("ext_rdata", ext_rdata, m_rdata);
    stall_run = cpu_stall ? stall_run + 1 : 0;
    wait_run  = (ext_req && !ext_gnt) ? wait_run + 1 : 0;
    chk("stall_bound", stall_run > MB, 0);
    chk("wait_bound",  wait_run > SL, 0);
    last_gnt = ext_gnt;
  endtask

  task automatic advance();
    bit own;
    @(posedge CLK);
    own = m_ext && ext_req;
    if (resetl) begin
      m_rv = 0; m_rdata = '0;
    end else begin
      m_rv = own && !ext_we;
      if (m_rv) m_rdata = exp_mem[ext_addr[10:3]];
    end
    if (own) begin
      if (ext_we) exp_mem[ext_addr[10:3]] = ext_wdata;
    end else if (cpu_write) begin
      exp_mem[cpu_addr[10:3]] = cpu_wdata;
    end
    if (resetl) begin
      m_ext = 0; m_wait = 0; m_beats = 0;
    end else if (m_ext) begin
      if (ext_req) begin
        m_beats++;
        if (m_beats == MB) m_ext = 0;
      end else begin
        m_ext = 0;
      end
    end else if (ext_req) begin
      if (!(cpu_read || cpu_write) || m_wait == SL - 1) begin
        m_ext = 1; m_wait = 0; m_beats = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
    end
    #1;
  endtask

  typedef struct {
    logic rd, wr; logic [63:0] ca, cw;
    logic er, ew; logic [63:0] ea, ewd;
    logic eg, st, mr, mw; logic [63:0] ma;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int b, c, first, bad;
    logic [15:0] pat;
    logic g, pend;
    logic [1:0] op;

    vecs[0] = '{1,0,64'h10,0,     0,0,64'h0,  0,      0,0,1,0,64'h10};
    vecs[1] = '{0,1,64'h18,64'h1111,1,1,64'h100,64'h5555, 0,0,0,1,64'h18};
    vecs[2] = '{0,0,64'h0, 0,     1,1,64'h100,64'h5555, 0,0,0,0,64'h0};
    vecs[3] = '{1,0,64'h20,0,     1,1,64'h100,64'h5555, 1,1,0,1,64'h100};
    vecs[4] = '{0,1,64'h28,64'h2222,0,0,64'h0,  0,      0,0,0,1,64'h28};
    vecs[5] = '{1,0,64'h30,0,     0,0,64'h0,  0,      0,0,1,0,64'h30};

    for (int k = 0; k < 256; k++) exp_mem[k] = '0;
    drive(0,0,0,0,0,0,0,0);
    resetl = 1; mem_clear = 1;
    repeat (2) @(posedge CLK);
    #1;
    resetl = 0; mem_clear = 0;
    m_ext = 0; m_wait = 0; m_beats = 0; m_rv = 0; m_rdata = '0;
    stall_run = 0; wait_run = 0; last_gnt = 0;

    chk("reset_state", dut.state, S_CPU);
    chk("reset_rvalid", ext_rvalid, 0);
    chk("reset_rdata", ext_rdata, 0);

    // Directed vectors: reset read, starve step, admission, stalled beat,
    // mid-burst drop with a pending CPU write, plain CPU read.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].ca, vecs[i].cw,
            vecs[i].er, vecs[i].ew, vecs[i].ea, vecs[i].ewd);
      sample();
      chk($sformatf("vec%0d_gnt", i),   ext_gnt,   vecs[i].eg);
      chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].st);
      chk($sformatf("vec%0d_mr", i),    mem_read,  vecs[i].mr);
      chk($sformatf("vec%0d_mw", i),    mem_write, vecs[i].mw);
      chk($sformatf("vec%0d_maddr", i), mem_addr,  vecs[i].ma);
      advance();
    end
    chk("drop_to_cpu_state", dut.state, S_CPU);

    // 6-beat external write burst with the CPU idle.
    b = 0; c = 0; pat = '0;
    while (b < 6 && c < 16) begin
      drive(0,0,0,0,1,1,64'h100 + 64'(8*b),64'hA000 + 64'(b));
      sample();
      pat[c] = ext_gnt;
      if (ext_gnt) b++;
      advance();
      c++;
    end
    drive(0,0,0,0,0,0,0,0); sample(); advance();
    chk("burst_pattern", pat, 16'h00DE);
    for (int k = 0; k < 6; k++)
      chk($sformatf("burst_mem%0d", k), mem[32+k], 64'hA000 + 64'(k));

    // External read return timing.
    drive(0,1,64'h40,64'hDEADBEEF,0,0,0,0); sample(); advance();
    g = 0; c = 0;
    while (!g && c < 10) begin
      drive(0,0,0,0,1,0,64'h40,0); sample(); g = ext_gnt; advance(); c++;
    end
    chk("read_granted", g, 1);
    drive(0,0,0,0,0,0,0,0); sample();
    chk("read_rvalid_n1", ext_rvalid, 1);
    chk("read_rdata_n1",  ext_rdata,  64'hDEADBEEF);
    advance();
    sample();
    chk("read_rvalid_n2", ext_rvalid, 0);
    advance();

    // Starvation bound with the CPU loading every cycle.
    first = -1; c = 0;
    while (first < 0 && c < 30) begin
      drive(1,0,64'h10,0,1,0,64'h40,0);
      sample();
      chk("starve_gnt",   ext_gnt,   c == SL);
      chk("starve_stall", cpu_stall, c == SL);
      if (ext_gnt) first = c;
      advance();
      c++;
    end
    chk("starve_first_gnt", first, SL);
    drive(1,0,64'h10,0,0,0,0,0); sample();
    chk("starve_release_stall", cpu_stall, 0);
    advance();

    // Reset pulsed during beat 2 of a read burst.
    drive(0,0,0,0,1,0,64'h100,0); sample(); advance();
    sample(); advance();
    drive(0,0,0,0,1,0,64'h108,0); resetl = 1;
    sample();
    chk("rst_beat_presented", mem_read, 1);
    advance();
    resetl = 0;
    sample();
    chk("rst_gnt",    ext_gnt,    0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_rdata",  ext_rdata,  0);
    chk("rst_state",  dut.state,  S_CPU);
    chk("rst_starve", dut.starve_cnt, 0);
    chk("rst_burst",  dut.burst_cnt,  0);
`ifdef DMEM_ARB_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 0);
    chk("rst_perf_beats", perf_ext_beats, 0);
`endif
    advance();
    drive(0,0,0,0,0,0,0,0); sample(); advance();

    // Random traffic; external payload is held until its beat is granted.
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      op = 2'($urandom_range(0, 3));
      cpu_read  = (op == 2'd1) || (op == 2'd3);
      cpu_write = (op == 2'd2);
      cpu_addr  = {53'd0, 8'($urandom_range(0, 255)), 3'd0};
      cpu_wdata = {$urandom, $urandom};
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend      = 1;
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = {53'd0, 8'($urandom_range(0, 255)), 3'd0};
        ext_wdata = {$urandom, $urandom};
      end
      ext_req = pend;
      sample();
      advance();
      if (last_gnt) pend = 0;
    end
    drive(0,0,0,0,0,0,0,0);
    repeat (3) begin sample(); advance(); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
    chk("mem_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
